// File: rtl/ysyx_reg_scoreboard.sv
// ysyx_reg_scoreboard
// Architectural register file with a per-register busy/tag scoreboard.
// Dispatch marks a destination busy with its producer tag; a commit writes
// the data and releases the register only when its tag matches the newest
// producer. Reads are combinational with commit-data bypass, and a
// registered counter tracks how many registers are busy.
module ysyx_reg_scoreboard #(
  parameter int XLEN       = 32,
  parameter int REG_NUM    = 16,
  parameter int REG_ADDR_W = 4,
  parameter int TAG_W      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [TAG_W-1:0]      issue_tag,
  input  logic                  commit_valid,
  input  logic [REG_ADDR_W-1:0] commit_rd,
  input  logic [TAG_W-1:0]      commit_tag,
  input  logic [XLEN-1:0]       commit_data,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [TAG_W-1:0]      rs1_tag,
  output logic [TAG_W-1:0]      rs2_tag,
  output logic [REG_NUM-1:0]    out_busy,
  output logic [REG_ADDR_W:0]   out_busy_cnt
);

  localparam logic [REG_ADDR_W-1:0] ADDR_ZERO = {REG_ADDR_W{1'b0}};
  localparam logic [REG_ADDR_W:0]   CNT_ONE   = {{REG_ADDR_W{1'b0}}, 1'b1};

  logic [XLEN-1:0]     rf_r [REG_NUM];
  logic [TAG_W-1:0]    tag_r [REG_NUM];
  logic [REG_NUM-1:0]  busy_r;
  logic [REG_ADDR_W:0] busy_cnt_r;

  logic                issue_en_s;
  logic                commit_en_s;
  logic                commit_clr_s;
  logic                cnt_inc_s;
  logic                cnt_dec_s;
  logic [REG_NUM-1:0]  busy_nxt_s;
  logic [REG_ADDR_W:0] cnt_nxt_s;

  // Decode issue/commit effects and compute next busy vector and count.
  always_comb begin
    issue_en_s   = issue_valid && (issue_rd != ADDR_ZERO) && !flush;
    commit_en_s  = commit_valid && (commit_rd != ADDR_ZERO);
    commit_clr_s = commit_en_s && busy_r[commit_rd] && (tag_r[commit_rd] == commit_tag);
    // A new producer only adds to the count if the register was idle; a
    // clearing commit is cancelled when a same-rd issue re-marks it busy.
    cnt_inc_s    = issue_en_s && !busy_r[issue_rd];
    cnt_dec_s    = commit_clr_s && !(issue_en_s && (issue_rd == commit_rd));
    busy_nxt_s   = {REG_NUM{1'b0}};
    for (int i = 0; i < REG_NUM; i++) begin
      busy_nxt_s[i] = flush ? 1'b0 :
                      (issue_en_s && (issue_rd == REG_ADDR_W'(i))) ? 1'b1 :
                      (commit_clr_s && (commit_rd == REG_ADDR_W'(i))) ? 1'b0 :
                      busy_r[i];
    end
    cnt_nxt_s = busy_cnt_r;
    if (flush) begin
      cnt_nxt_s = {(REG_ADDR_W+1){1'b0}};
    end else begin
      case ({cnt_inc_s, cnt_dec_s})
        2'b10:   cnt_nxt_s = busy_cnt_r + CNT_ONE;
        2'b01:   cnt_nxt_s = busy_cnt_r - CNT_ONE;
        default: cnt_nxt_s = busy_cnt_r;
      endcase
    end
  end

  // State update: data writes, producer tags, busy bits and busy count.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) begin
        rf_r[i]  <= {XLEN{1'b0}};
        tag_r[i] <= {TAG_W{1'b0}};
      end
      busy_r     <= {REG_NUM{1'b0}};
      busy_cnt_r <= {(REG_ADDR_W+1){1'b0}};
    end else begin
      if (commit_en_s) begin
        rf_r[commit_rd] <= commit_data;
      end
      if (issue_en_s) begin
        tag_r[issue_rd] <= issue_tag;
      end
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= cnt_nxt_s;
    end
  end

  // Read ports: register 0 is hard zero, same-cycle commit data is bypassed,
  // and a matching same-cycle commit hides the pending state.
  assign rs1_data = (rs1_addr == ADDR_ZERO) ? {XLEN{1'b0}} :
                    (commit_valid && (commit_rd == rs1_addr)) ? commit_data : rf_r[rs1_addr];
  assign rs2_data = (rs2_addr == ADDR_ZERO) ? {XLEN{1'b0}} :
                    (commit_valid && (commit_rd == rs2_addr)) ? commit_data : rf_r[rs2_addr];
  assign rs1_busy = busy_r[rs1_addr] &&
                    !(commit_valid && (commit_rd == rs1_addr) && (commit_tag == tag_r[rs1_addr]));
  assign rs2_busy = busy_r[rs2_addr] &&
                    !(commit_valid && (commit_rd == rs2_addr) && (commit_tag == tag_r[rs2_addr]));
  assign rs1_tag  = tag_r[rs1_addr];
  assign rs2_tag  = tag_r[rs2_addr];

  assign out_busy     = busy_r;
  assign out_busy_cnt = busy_cnt_r;

endmodule

// File: tb/tb_ysyx_reg_scoreboard.sv
// tb_ysyx_reg_scoreboard
// Table-driven bench: each record holds one cycle of inputs plus the outputs
// expected before the following clock edge. Expectations are queued when the
// stimulus is driven and popped when the outputs are sampled on the falling edge.
module tb_ysyx_reg_scoreboard;

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [3:0]  ird;
    logic [3:0]  itag;
    logic        cv;
    logic [3:0]  crd;
    logic [3:0]  ctag;
    logic [31:0] cdata;
    logic        fl;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
  } in_t;

  typedef struct packed {
    logic [31:0] d1;
    logic        b1;
    logic [3:0]  t1;
    logic [31:0] d2;
    logic        b2;
    logic [3:0]  t2;
    logic [15:0] ob;
    logic [4:0]  cnt;
  } exp_t;

  typedef struct packed {
    in_t  in;
    exp_t ex;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [3:0]  issue_rd;
  logic [3:0]  issue_tag;
  logic        commit_valid;
  logic [3:0]  commit_rd;
  logic [3:0]  commit_tag;
  logic [31:0] commit_data;
  logic        flush;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [3:0]  rs1_tag;
  logic [3:0]  rs2_tag;
  logic [15:0] out_busy;
  logic [4:0]  out_busy_cnt;

  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];
  vec_t vt[25];

  ysyx_reg_scoreboard #(
    .XLEN(32), .REG_NUM(16), .REG_ADDR_W(4), .TAG_W(4)
  ) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_data(commit_data), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .out_busy(out_busy), .out_busy_cnt(out_busy_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(
    input logic rst, input logic iv, input logic [3:0] ird, input logic [3:0] itag,
    input logic cv, input logic [3:0] crd, input logic [3:0] ctag, input logic [31:0] cdata,
    input logic fl, input logic [3:0] rs1, input logic [3:0] rs2,
    input logic [31:0] d1, input logic b1, input logic [3:0] t1,
    input logic [31:0] d2, input logic b2, input logic [3:0] t2,
    input logic [15:0] ob, input logic [4:0] cnt);
    vec_t v;
    v.in = '{rst, iv, ird, itag, cv, crd, ctag, cdata, fl, rs1, rs2};
    v.ex = '{d1, b1, t1, d2, b2, t2, ob, cnt};
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, req);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then sample and compare.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    @(posedge clock);
    #1;
    reset        = v.in.rst;
    issue_valid  = v.in.iv;
    issue_rd     = v.in.ird;
    issue_tag    = v.in.itag;
    commit_valid = v.in.cv;
    commit_rd    = v.in.crd;
    commit_tag   = v.in.ctag;
    commit_data  = v.in.cdata;
    flush        = v.in.fl;
    rs1_addr     = v.in.rs1;
    rs2_addr     = v.in.rs2;
    exp_q.push_back(v.ex);
    @(negedge clock);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty step %0d: got 0 entries, expected 1", idx);
    end else begin
      e = exp_q.pop_front();
      chk("rs1_data", idx, rs1_data, e.d1);
      chk("rs1_busy", idx, 32'(rs1_busy), 32'(e.b1));
      chk("rs1_tag", idx, 32'(rs1_tag), 32'(e.t1));
      chk("rs2_data", idx, rs2_data, e.d2);
      chk("rs2_busy", idx, 32'(rs2_busy), 32'(e.b2));
      chk("rs2_tag", idx, 32'(rs2_tag), 32'(e.t2));
      chk("out_busy", idx, 32'(out_busy), 32'(e.ob));
      chk("out_busy_cnt", idx, 32'(out_busy_cnt), 32'(e.cnt));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //          rst iv rd tg  cv rd tg data           fl rs1 rs2 | d1 b1 t1 | d2 b2 t2 | out_busy cnt
    vt[0]  = mk(0, 0,0,0,    0,0,0,32'h0,           0, 0,5,  32'h0,0,0,          32'h0,0,0,  16'h0000,5'd0);
    vt[1]  = mk(0, 1,5,3,    0,0,0,32'h0,           0, 5,0,  32'h0,0,0,          32'h0,0,0,  16'h0000,5'd0);
    vt[2]  = mk(0, 0,0,0,    0,0,0,32'h0,           0, 5,0,  32'h0,1,3,          32'h0,0,0,  16'h0020,5'd1);
    vt[3]  = mk(0, 0,0,0,    1,5,3,32'hDEADBEEF,    0, 5,0,  32'hDEADBEEF,0,3,   32'h0,0,0,  16'h0020,5'd1);
    vt[4]  = mk(0, 0,0,0,    0,0,0,32'h0,           0, 5,0,  32'hDEADBEEF,0,3,   32'h0,0,0,  16'h0000,5'd0);
    vt[5]  = mk(0, 1,7,1,    0,0,0,32'h0,           0, 7,0,  32'h0,0,0,          32'h0,0,0,  16'h0000,5'd0);
    vt[6]  = mk(0, 1,7,2,    0,0,0,32'h0,           0, 7,0,  32'h0,1,1,          32'h0,0,0,  16'h0080,5'd1);
    vt[7]  = mk(0, 0,0,0,    1,7,1,32'h11,          0, 7,0,  32'h11,1,2,         32'h0,0,0,  16'h0080,5'd1);
    vt[8]  = mk(0, 0,0,0,    0,0,0,32'h0,           0, 7,0,  32'h11,1,2,         32'h0,0,0,  16'h0080,5'd1);
    vt[9]  = mk(0, 1,7,4,    1,7,2,32'h22,          0, 7,0,  32'h22,0,2,         32'h0,0,0,  16'h0080,5'd1);
    vt[10] = mk(0, 0,0,0,    0,0,0,32'h0,           0, 7,0,  32'h22,1,4,         32'h0,0,0,  16'h0080,5'd1);
    vt[11] = mk(0, 0,0,0,    1,7,4,32'h33,          0, 7,0,  32'h33,0,4,         32'h0,0,0,  16'h0080,5'd1);
    vt[12] = mk(0, 0,0,0,    0,0,0,32'h0,           0, 7,0,  32'h33,0,4,         32'h0,0,0,  16'h0000,5'd0);
    vt[13] = mk(0, 1,2,5,    0,0,0,32'h0,           0, 2,0,  32'h0,0,0,          32'h0,0,0,  16'h0000,5'd0);
    vt[14] = mk(0, 1,3,6,    0,0,0,32'h0,           0, 2,0,  32'h0,1,5,          32'h0,0,0,  16'h0004,5'd1);
    vt[15] = mk(0, 1,4,7,    0,0,0,32'h0,           0, 3,0,  32'h0,1,6,          32'h0,0,0,  16'h000C,5'd2);
    vt[16] = mk(0, 1,6,8,    1,2,5,32'h44,          1, 4,2,  32'h0,1,7,          32'h44,0,5, 16'h001C,5'd3);
    vt[17] = mk(0, 0,0,0,    0,0,0,32'h0,           0, 6,2,  32'h0,0,0,          32'h44,0,5, 16'h0000,5'd0);
    vt[18] = mk(0, 1,9,10,   0,0,0,32'h0,           0, 9,0,  32'h0,0,0,          32'h0,0,0,  16'h0000,5'd0);
    vt[19] = mk(0, 1,10,11,  1,9,10,32'h55,         0, 9,0,  32'h55,0,10,        32'h0,0,0,  16'h0200,5'd1);
    vt[20] = mk(0, 0,0,0,    0,0,0,32'h0,           0, 10,9, 32'h0,1,11,         32'h55,0,10,16'h0400,5'd1);
    vt[21] = mk(0, 1,0,15,   1,0,0,32'hFF,          0, 0,0,  32'h0,0,0,          32'h0,0,0,  16'h0400,5'd1);
    vt[22] = mk(0, 0,0,0,    0,0,0,32'h0,           0, 0,0,  32'h0,0,0,          32'h0,0,0,  16'h0400,5'd1);
    vt[23] = mk(0, 0,0,0,    1,10,3,32'h66,         0, 10,0, 32'h66,1,11,        32'h0,0,0,  16'h0400,5'd1);
    vt[24] = mk(0, 0,0,0,    0,0,0,32'h0,           0, 10,0, 32'h66,1,11,        32'h0,0,0,  16'h0400,5'd1);

    reset        = 1'b1;
    issue_valid  = 1'b0;
    issue_rd     = 4'd0;
    issue_tag    = 4'd0;
    commit_valid = 1'b0;
    commit_rd    = 4'd0;
    commit_tag   = 4'd0;
    commit_data  = 32'h0;
    flush        = 1'b0;
    rs1_addr     = 4'd0;
    rs2_addr     = 4'd0;
    repeat (2) @(posedge clock);

    for (int i = 0; i < 25; i++) begin
      apply(i, vt[i]);
    end

    // Reset in the middle of activity: busy registers plus a pending commit.
    apply(100, mk(0, 1,12,1, 0,0,0,32'h0,  0, 10,0, 32'h66,1,11, 32'h0,0,0, 16'h0400,5'd1));
    apply(101, mk(1, 1,13,2, 1,12,1,32'h77, 0, 12,0, 32'h77,0,1,  32'h0,0,0, 16'h1400,5'd2));
    apply(102, mk(0, 0,0,0,  0,0,0,32'h0,  0, 12,10, 32'h0,0,0,  32'h0,0,0, 16'h0000,5'd0));
    apply(103, mk(0, 0,0,0,  0,0,0,32'h0,  0, 5,7,   32'h0,0,0,  32'h0,0,0, 16'h0000,5'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
